// File: rtl/volume_meter_if.sv
// Control/data bundle between the APU volume source and the LED meter.
// The master drives volumes and controls; the slave returns the levels and PWM outputs.
interface volume_meter_if #(
    parameter int CHANNELS  = 5,
    parameter int VOL_WIDTH = 4
);
    logic                            tick_en;
    logic [CHANNELS*VOL_WIDTH-1:0]   volumes;
    logic [CHANNELS-1:0]             mute;
    logic                            peak_mode;
    logic [CHANNELS*VOL_WIDTH-1:0]   level;
    logic [CHANNELS-1:0]             pwm_out;

    modport master (
        output tick_en, volumes, mute, peak_mode,
        input  level, pwm_out
    );

    modport slave (
        input  tick_en, volumes, mute, peak_mode,
        output level, pwm_out
    );
endinterface

// File: rtl/volume_meter.sv
// Multi-channel sound-level meter: per-channel level tracking with optional
// peak-hold/decay, square-law duty, and one shared PWM counter.
module volume_meter #(
    parameter int CHANNELS   = 5,
    parameter int VOL_WIDTH  = 4,
    parameter int PWM_WIDTH  = 8,
    parameter int HOLD_TICKS = 30
) (
    input  logic          clk,
    input  logic          reset,
    volume_meter_if.slave bus
);
    localparam int SQ_W   = 2 * VOL_WIDTH;
    localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS);

    logic [PWM_WIDTH-1:0] cnt_q, cnt_d;
    logic [VOL_WIDTH-1:0] level_arr [CHANNELS];
    logic                 pwm_arr   [CHANNELS];
    logic [CHANNELS*VOL_WIDTH-1:0] level_flat;
    logic [CHANNELS-1:0]           pwm_flat;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [VOL_WIDTH-1:0] v_q, v_d;
        logic [VOL_WIDTH-1:0] l_q, l_d;
        logic [HOLD_W-1:0]    hold_q, hold_d;
        logic [PWM_WIDTH-1:0] duty_q, duty_d;
        logic                 pwm_q, pwm_d;
        logic [SQ_W-1:0]      sq;
        logic [PWM_WIDTH-1:0] duty;

        // A fresh peak (v >= L) takes precedence over a decay tick.
        always_comb begin
            v_d    = bus.volumes[gi*VOL_WIDTH +: VOL_WIDTH];
            l_d    = l_q;
            hold_d = hold_q;
            if (bus.mute[gi]) begin
                l_d    = '0;
                hold_d = '0;
            end else if (!bus.peak_mode) begin
                l_d    = v_q;
                hold_d = '0;
            end else if (v_q >= l_q) begin
                l_d    = v_q;
                hold_d = HOLD_INIT;
            end else if (bus.tick_en) begin
                if (hold_q != '0)    hold_d = hold_q - 1'b1;
                else if (l_q != '0)  l_d    = l_q - 1'b1;
            end
        end

        always_comb begin
            sq = SQ_W'(l_q) * SQ_W'(l_q);
        end

        if (PWM_WIDTH >= SQ_W) begin : g_widen
            always_comb duty = PWM_WIDTH'(sq) << (PWM_WIDTH - SQ_W);
        end else begin : g_narrow
            always_comb duty = PWM_WIDTH'(sq >> (SQ_W - PWM_WIDTH));
        end

        // Duty only changes at the period boundary so every period is whole.
        always_comb begin
            duty_d = (cnt_q == '1) ? duty : duty_q;
            pwm_d  = (cnt_q < duty_q);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q    <= '0;
                l_q    <= '0;
                hold_q <= '0;
                duty_q <= '0;
                pwm_q  <= 1'b0;
            end else begin
                v_q    <= v_d;
                l_q    <= l_d;
                hold_q <= hold_d;
                duty_q <= duty_d;
                pwm_q  <= pwm_d;
            end
        end

        assign level_arr[gi] = l_q;
        assign pwm_arr[gi]   = pwm_q;
    end

    always_comb begin
        level_flat = '0;
        pwm_flat   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            level_flat[i*VOL_WIDTH +: VOL_WIDTH] = level_arr[i];
            pwm_flat[i]                          = pwm_arr[i];
        end
    end

    assign bus.level   = level_flat;
    assign bus.pwm_out = pwm_flat;
endmodule

// File: tb/tb_volume_meter.sv
// Scoreboard bench for volume_meter: default 5-channel/8-bit PWM instance
// plus an 8-channel/10-bit PWM instance run side by side.
module tb_volume_meter;
    localparam int CH  = 5;
    localparam int CH2 = 8;
    localparam int VW  = 4;
    localparam int P0  = 256;
    localparam int P1  = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    volume_meter_if #(.CHANNELS(CH),  .VOL_WIDTH(VW)) bus0 ();
    volume_meter_if #(.CHANNELS(CH2), .VOL_WIDTH(VW)) bus1 ();

    volume_meter #(.CHANNELS(CH), .VOL_WIDTH(VW), .PWM_WIDTH(8), .HOLD_TICKS(30)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );
    volume_meter #(.CHANNELS(CH2), .VOL_WIDTH(VW), .PWM_WIDTH(10), .HOLD_TICKS(30)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    typedef struct {
        int due;
        int dut;
        int kind;   // 0 = level at cycle 'due', 1 = pwm high count of window ending at 'due'
        int ch;
        int exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   hi0 [CH];
    int   hi1 [CH2];

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lvl(input int dut, input int ch);
        if (dut == 0) return int'(bus0.level[ch*VW +: VW]);
        return int'(bus1.level[ch*VW +: VW]);
    endfunction

    function automatic int win_end(input int t, input int p);
        return ((t + p) / p) * p + p;
    endfunction

    task automatic push(input int due, input int dut, input int kind, input int ch, input int exp);
        exp_t e;
        e.due = due; e.dut = dut; e.kind = kind; e.ch = ch; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic set_vol(input int ch, input int v);
        bus0.volumes[ch*VW +: VW] = VW'(v);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: accumulate per-period high counts and retire due expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int i = 0; i < CH; i++)
                    hi0[i] = (cyc % P0 == 1) ? int'(bus0.pwm_out[i]) : hi0[i] + int'(bus0.pwm_out[i]);
                for (int i = 0; i < CH2; i++)
                    hi1[i] = (cyc % P1 == 1) ? int'(bus1.pwm_out[i]) : hi1[i] + int'(bus1.pwm_out[i]);
                for (int k = sb.size() - 1; k >= 0; k--) begin
                    if (sb[k].due <= cyc) begin
                        if (sb[k].due < cyc)
                            chk("late", cyc, sb[k].due);
                        else if (sb[k].kind == 0)
                            chk($sformatf("level d%0d ch%0d @%0d", sb[k].dut, sb[k].ch, cyc),
                                lvl(sb[k].dut, sb[k].ch), sb[k].exp);
                        else if (sb[k].dut == 0)
                            chk($sformatf("pwm_hi d0 ch%0d @%0d", sb[k].ch, cyc), hi0[sb[k].ch], sb[k].exp);
                        else
                            chk($sformatf("pwm_hi d1 ch%0d @%0d", sb[k].ch, cyc), hi1[sb[k].ch], sb[k].exp);
                        sb.delete(k);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.volumes = '0; bus0.mute = '0; bus0.peak_mode = 1'b0; bus0.tick_en = 1'b0;
        bus1.volumes = '1; bus1.mute = '0; bus1.peak_mode = 1'b0; bus1.tick_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst level0", bus0.level, 0);
        chk("rst pwm0", bus0.pwm_out, 0);
        chk("rst level1", bus1.level, 0);
        chk("rst pwm1", bus1.pwm_out, 0);

        // Full scale on both instances; dut0 ch4 left at zero.
        for (int i = 0; i < CH2; i++) begin
            push(cyc + 2, 1, 0, i, 15);
            push(win_end(cyc + 2, P1), 1, 1, i, 900);
        end
        for (int i = 0; i < CH; i++) begin
            set_vol(i, (i == 4) ? 0 : 15);
            push(cyc + 2, 0, 0, i, (i == 4) ? 0 : 15);
            push(win_end(cyc + 2, P0), 0, 1, i, (i == 4) ? 0 : 225);
        end

        // ch0 3 -> 5 mid-period: old duty holds until the wrap.
        wait_cyc(520);
        bus0.volumes = '0;
        set_vol(0, 3);
        push(cyc + 2, 0, 0, 0, 3);
        push(win_end(cyc + 2, P0), 0, 1, 0, 9);
        wait_cyc(1124);
        set_vol(0, 5);
        push(cyc + 2, 0, 0, 0, 5);
        push(win_end(cyc + 2, P0) - P0, 0, 1, 0, 9);
        push(win_end(cyc + 2, P0), 0, 1, 0, 25);

        // Mute ch2 while it carries 4'hA; ch0/ch3 unaffected.
        wait_cyc(1540);
        set_vol(2, 10);
        set_vol(3, 7);
        bus0.mute = 5'b00100;
        push(cyc + 2, 0, 0, 2, 0);
        push(cyc + 2, 0, 0, 3, 7);
        push(win_end(cyc + 2, P0), 0, 1, 2, 0);
        push(win_end(cyc + 2, P0), 0, 1, 0, 25);
        wait_cyc(2050);
        bus0.mute = '0;
        push(cyc + 2, 0, 0, 2, 10);
        push(win_end(cyc + 2, P0), 0, 1, 2, 100);

        // Peak hold and decay on ch1.
        wait_cyc(2600);
        bus0.peak_mode = 1'b1;
        set_vol(1, 12);
        push(cyc + 2, 0, 0, 1, 12);
        @(negedge clk);
        set_vol(1, 0);
        for (int i = 1; i <= 45; i++) begin
            wait_cyc(2600 + 10 * i);
            bus0.tick_en = 1'b1;
            push(cyc + 1, 0, 0, 1, (i <= 30) ? 12 : ((12 - (i - 30)) > 0 ? 12 - (i - 30) : 0));
            @(negedge clk);
            bus0.tick_en = 1'b0;
        end

        // New peak coincident with tick_en on ch4 (level 6 -> 8, hold reloaded).
        wait_cyc(3100);
        set_vol(4, 6);
        push(cyc + 2, 0, 0, 4, 6);
        wait_cyc(3110);
        set_vol(4, 8);
        @(negedge clk);
        set_vol(4, 0);
        bus0.tick_en = 1'b1;
        push(cyc + 1, 0, 0, 4, 8);
        @(negedge clk);
        bus0.tick_en = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            wait_cyc(3110 + 10 * i);
            bus0.tick_en = 1'b1;
            push(cyc + 1, 0, 0, 4, (i <= 30) ? 8 : 7);
            @(negedge clk);
            bus0.tick_en = 1'b0;
        end

        // Reset in the middle of an active period.
        wait_cyc(3500);
        bus0.peak_mode = 1'b0;
        bus0.volumes = '1;
        push(cyc + 2, 0, 0, 0, 15);
        wait_cyc(3590);
        chk("pre-reset pwm0", bus0.pwm_out, 5'b11111);
        for (int n = 0; n < 3000 && sb.size() != 0; n++) @(negedge clk);
        chk("scoreboard drained", sb.size(), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid reset level0", bus0.level, 0);
        chk("mid reset pwm0", bus0.pwm_out, 0);
        chk("mid reset pwm1", bus1.pwm_out, 0);
        reset = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
